// File: rtl/ball_motion_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared types and helpers for the pong ball engine: FSM state
//               enum, wide signed velocity type and centre-position function.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SERVE  = 2'd1,
      MOVE   = 2'd2,
      SCORED = 2'd3
   } state_t;

   // Wide signed velocity used for speed-magnitude arithmetic
   localparam int VEL_W = 8;
   typedef logic signed [VEL_W-1:0] vel_t;

   // Centre coordinate of an axis spanning 0..max_coord
   function automatic int centre(input int max_coord);
      return max_coord / 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ball_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ball_motion_ctrl_if
// Description : Control/status bundle between the game logic (master) and
//               the ball engine (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ball_motion_ctrl_if #(
   parameter int X_BITS     = 3,
   parameter int Y_BITS     = 3,
   parameter int SPEED_BITS = 2
);
   logic                          start;
   logic                          tick;
   logic [Y_BITS-1:0]             paddle_l_y;
   logic [Y_BITS-1:0]             paddle_r_y;
   logic [X_BITS+Y_BITS-1:0]      pos;
   logic [2*(SPEED_BITS+1)-1:0]   vel;
   logic [1:0]                    state;
   logic                          score_l;
   logic                          score_r;

   modport master (
      output start, tick, paddle_l_y, paddle_r_y,
      input  pos, vel, state, score_l, score_r
   );

   modport slave (
      input  start, tick, paddle_l_y, paddle_r_y,
      output pos, vel, state, score_l, score_r
   );
endinterface
`default_nettype wire

// File: rtl/ball_motion_ctrl_axis_step.sv
`default_nettype none
// ============================================================================
// Module      : ball_axis_step
// Description : One-axis step: next = coord + vel, clamped into [lo, hi],
//               with flags telling which bound was crossed.
// Revision    : 1.0 - initial release
// ============================================================================
module ball_axis_step #(
   parameter int W = 7
) (
   input  wire logic signed [W-1:0] coord,
   input  wire logic signed [W-1:0] vel,
   input  wire logic signed [W-1:0] lo,
   input  wire logic signed [W-1:0] hi,
   output logic signed [W-1:0]      next,
   output logic                     below,
   output logic                     above
);
   logic signed [W-1:0] w_sum;

   assign w_sum = coord + vel;
   assign below = (w_sum < lo);
   assign above = (w_sum > hi);
   assign next  = below ? lo : (above ? hi : w_sum);
endmodule
`default_nettype wire

// File: rtl/ball_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ball_motion_ctrl
// Description : Pong ball engine. Holds position and signed velocity, steps
//               the ball on tick strobes, reflects on walls and paddle hits,
//               pulses a score on a miss and re-serves from the centre.
//               Optional macro BALL_SPEEDUP_EN: each paddle hit raises |vx|
//               by one, saturating at MAX_SPEED.
// Revision    : 1.0 - initial release
// ============================================================================
module ball_motion_ctrl
   import pong_pkg::*;
#(
   parameter int X_BITS      = 3,
   parameter int Y_BITS      = 3,
   parameter int X_MAX       = 7,
   parameter int Y_MAX       = 7,
   parameter int PADDLE_H    = 3,
   parameter int SPEED_BITS  = 2,
   parameter int MAX_SPEED   = 2,
   parameter int TICK_DIV    = 1,
   parameter int SERVE_TICKS = 2
) (
   input wire logic           clk,
   input wire logic           rst,
   ball_motion_ctrl_if.slave  bus
);
   localparam int W     = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + SPEED_BITS + 2;
   localparam int WP    = W + 1;
   localparam int VW    = SPEED_BITS + 1;
   localparam int XC    = centre(X_MAX);
   localparam int YC    = centre(Y_MAX);
   localparam int DIV_W = $clog2(TICK_DIV + 1);
   localparam int SRV_W = $clog2(SERVE_TICKS + 1);
`ifdef BALL_SPEEDUP_EN
   localparam int SPEED_CAP = MAX_SPEED;
`else
   // Fixed unit speed; the ceiling parameter is kept in the expression only
   // so both builds share one parameter list.
   localparam int SPEED_CAP = 1 + 0 * MAX_SPEED;
`endif

   localparam logic signed [VW-1:0] V_ONE  = VW'(1);
   localparam logic signed [W-1:0]  X_LO   = W'(1);
   localparam logic signed [W-1:0]  X_HI   = W'(X_MAX - 1);
   localparam logic signed [W-1:0]  Y_LO   = W'(0);
   localparam logic signed [W-1:0]  Y_HI   = W'(Y_MAX);

   state_t                  r_state, w_state;
   logic [X_BITS-1:0]       r_x, w_x;
   logic [Y_BITS-1:0]       r_y, w_y;
   logic signed [VW-1:0]    r_vx, w_vx, r_vy, w_vy;
   logic [DIV_W-1:0]        r_div, w_div;
   logic [SRV_W-1:0]        r_srv, w_srv;
   logic                    r_serve_right, w_serve_right;
   logic                    r_score_l, w_score_l, r_score_r, w_score_r;

   logic signed [W-1:0]     w_x_cur, w_y_cur, w_vx_ext, w_vy_ext;
   logic signed [W-1:0]     w_x_clamp, w_y_new;
   logic                    w_x_lo, w_x_hi, w_y_lo, w_y_hi;
   logic [WP-1:0]           w_y_new_u, w_pl_top, w_pl_bot, w_pr_top, w_pr_bot;
   logic                    w_hit_l, w_hit_r;
   vel_t                    w_vx_mag, w_hit_mag;

   assign w_x_cur  = $signed(W'(r_x));
   assign w_y_cur  = $signed(W'(r_y));
   assign w_vx_ext = W'(r_vx);
   assign w_vy_ext = W'(r_vy);

   // x is clamped to the live columns; crossing either bound means the paddle column was reached
   ball_axis_step #(.W(W)) u_step_x (
      .coord(w_x_cur), .vel(w_vx_ext), .lo(X_LO), .hi(X_HI),
      .next(w_x_clamp), .below(w_x_lo), .above(w_x_hi)
   );

   ball_axis_step #(.W(W)) u_step_y (
      .coord(w_y_cur), .vel(w_vy_ext), .lo(Y_LO), .hi(Y_HI),
      .next(w_y_new), .below(w_y_lo), .above(w_y_hi)
   );

   // Paddle span compared one bit wider than the coordinate so it never wraps
   assign w_y_new_u = {1'b0, w_y_new};
   assign w_pl_top  = WP'(bus.paddle_l_y);
   assign w_pl_bot  = w_pl_top + WP'(PADDLE_H - 1);
   assign w_pr_top  = WP'(bus.paddle_r_y);
   assign w_pr_bot  = w_pr_top + WP'(PADDLE_H - 1);
   assign w_hit_l   = (w_y_new_u >= w_pl_top) && (w_y_new_u <= w_pl_bot);
   assign w_hit_r   = (w_y_new_u >= w_pr_top) && (w_y_new_u <= w_pr_bot);

   // Speed after a paddle hit: one faster, saturating at the cap
   assign w_vx_mag  = r_vx[VW-1] ? -vel_t'(r_vx) : vel_t'(r_vx);
   assign w_hit_mag = (w_vx_mag >= vel_t'(SPEED_CAP)) ? vel_t'(SPEED_CAP)
                                                      : w_vx_mag + vel_t'(1);

   // Next-state, step and score logic
   always_comb begin
      w_state       = r_state;
      w_x           = r_x;
      w_y           = r_y;
      w_vx          = r_vx;
      w_vy          = r_vy;
      w_div         = r_div;
      w_srv         = r_srv;
      w_serve_right = r_serve_right;
      w_score_l     = 1'b0;
      w_score_r     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) w_state = SERVE;
         end
         SERVE: begin
            if (bus.tick) begin
               if (r_srv == SRV_W'(SERVE_TICKS - 1)) begin
                  w_srv   = '0;
                  w_state = MOVE;
                  w_vx    = r_serve_right ? V_ONE : -V_ONE;
                  w_vy    = V_ONE;
               end else begin
                  w_srv = r_srv + SRV_W'(1);
               end
            end
         end
         MOVE: begin
            if (bus.tick) begin
               if (r_div == DIV_W'(TICK_DIV - 1)) begin
                  w_div = '0;
                  w_y   = Y_BITS'(w_y_new);
                  w_vy  = (w_y_lo || w_y_hi) ? -r_vy : r_vy;
                  if (w_x_lo) begin
                     if (w_hit_l) begin
                        w_x  = X_BITS'(w_x_clamp);
                        w_vx = VW'(w_hit_mag);
                     end else begin
                        w_x           = '0;
                        w_state       = SCORED;
                        w_score_r     = 1'b1;
                        w_serve_right = 1'b1;
                     end
                  end else if (w_x_hi) begin
                     if (w_hit_r) begin
                        w_x  = X_BITS'(w_x_clamp);
                        w_vx = VW'(-w_hit_mag);
                     end else begin
                        w_x           = X_BITS'(X_MAX);
                        w_state       = SCORED;
                        w_score_l     = 1'b1;
                        w_serve_right = 1'b0;
                     end
                  end else begin
                     w_x = X_BITS'(w_x_clamp);
                  end
               end else begin
                  w_div = r_div + DIV_W'(1);
               end
            end
         end
         SCORED: begin
            w_state = SERVE;
            w_x     = X_BITS'(XC);
            w_y     = Y_BITS'(YC);
         end
         default: w_state = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state;
   end

   // Ball position, velocity, counters and score pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x           <= X_BITS'(XC);
         r_y           <= Y_BITS'(YC);
         r_vx          <= V_ONE;
         r_vy          <= V_ONE;
         r_div         <= '0;
         r_srv         <= '0;
         r_serve_right <= 1'b1;
         r_score_l     <= 1'b0;
         r_score_r     <= 1'b0;
      end else begin
         r_x           <= w_x;
         r_y           <= w_y;
         r_vx          <= w_vx;
         r_vy          <= w_vy;
         r_div         <= w_div;
         r_srv         <= w_srv;
         r_serve_right <= w_serve_right;
         r_score_l     <= w_score_l;
         r_score_r     <= w_score_r;
      end
   end

   assign bus.pos     = {r_x, r_y};
   assign bus.vel     = {r_vx, r_vy};
   assign bus.state   = r_state;
   assign bus.score_l = r_score_l;
   assign bus.score_r = r_score_r;
endmodule
`default_nettype wire
